lvds_rx_align_ctrl: RTL

- Bit-domain controller in front of the 4-lane LVDS 7:1 receiver datapath. It finds the frame boundary from the sampled LVDS clock lane, then qualifies 28-bit words for the downstream pixel pipeline.
- Runs on the serial bit clock and sequences capture: SEARCH (bit-slip), VERIFY, LOCKED, with loss-of-lock recovery.
- Outputs a qualified 28-bit word with a 1-cycle valid strobe, plus lock and status.

---
 rtl/lvds_rx_pkg.sv | 21 ++
 rtl/lvds_rx_align_ctrl_if.sv | 35 +++
 rtl/lvds_frame_shifter.sv | 76 +++++++
 rtl/lvds_rx_align_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the LVDS 7:1 receive alignment controller.
// Pure declarations: no logic, no latency, no flow control.
package lvds_rx_pkg;

  localparam int LVDS_BITS_PER_FRAME = 7;
  localparam int LVDS_LANES          = 4;
  localparam int LVDS_WORD_BITS      = LVDS_BITS_PER_FRAME * LVDS_LANES;

  localparam logic [LVDS_BITS_PER_FRAME-1:0] DEFAULT_CLK_PATTERN = 7'b1100011;

  typedef logic [LVDS_BITS_PER_FRAME-1:0] frame_word_t;
  typedef logic [LVDS_WORD_BITS-1:0]      lvds_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } align_state_e;

endpackage

// File: rtl/lvds_rx_align_ctrl_if.sv
// Serial-lane inputs and qualified-word outputs of the alignment controller; no backpressure.
// Statistics counters are present only when LVDS_ALIGN_STATS_EN is defined.
interface lvds_rx_align_ctrl_if;
  import lvds_rx_pkg::*;

  logic                  enable;
  logic                  lvds_clk_bit;
  logic [LVDS_LANES-1:0] lvds_data_bit;
  lvds_word_t            data_out;
  logic                  data_valid;
  logic                  locked;
  logic                  slip_pulse;
  logic                  align_err;
`ifdef LVDS_ALIGN_STATS_EN
  logic [7:0]            relock_cnt;
  logic [15:0]           frame_err_cnt;
`endif

  modport master (
`ifdef LVDS_ALIGN_STATS_EN
    input  relock_cnt, frame_err_cnt,
`endif
    output enable, lvds_clk_bit, lvds_data_bit,
    input  data_out, data_valid, locked, slip_pulse, align_err
  );

  modport slave (
`ifdef LVDS_ALIGN_STATS_EN
    output relock_cnt, frame_err_cnt,
`endif
    input  enable, lvds_clk_bit, lvds_data_bit,
    output data_out, data_valid, locked, slip_pulse, align_err
  );

endinterface

// File: rtl/lvds_frame_shifter.sv
// Bit counter, slip hold and 7-bit capture registers; frame word is combinational at frame end.
// Slip request at frame end discards the next bit; no backpressure.
module lvds_frame_shifter
  import lvds_rx_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  slip_req,
  input  logic                  lvds_clk_bit,
  input  logic [LVDS_LANES-1:0] lvds_data_bit,
  output frame_word_t           clk_word,
  output lvds_word_t            data_word,
  output logic                  frame_end,
  output logic                  slip_pulse
);

  localparam logic [2:0] LAST_IDX = 3'(LVDS_BITS_PER_FRAME - 1);

  logic [2:0]                     bit_idx_q, bit_idx_d;
  logic                           slip_pending_q, slip_pending_d;
  frame_word_t                    clk_sr_q, clk_sr_d;
  frame_word_t [LVDS_LANES-1:0]   lane_sr_q, lane_sr_d;
  logic [2:0]                     wr_pos;

  assign wr_pos     = LAST_IDX - bit_idx_q;
  assign frame_end  = run && !slip_pending_q && (bit_idx_q == LAST_IDX);
  assign slip_pulse = slip_pending_q;

  always_comb begin
    bit_idx_d      = bit_idx_q;
    slip_pending_d = slip_pending_q;
    clk_sr_d       = clk_sr_q;
    lane_sr_d      = lane_sr_q;
    if (!run) begin
      bit_idx_d      = '0;
      slip_pending_d = 1'b0;
      clk_sr_d       = '0;
      lane_sr_d      = '0;
    end else if (slip_pending_q) begin
      // Discard cycle: bit_idx holds at 0, this cycle's bits are dropped.
      slip_pending_d = 1'b0;
      bit_idx_d      = '0;
    end else begin
      clk_sr_d[wr_pos] = lvds_clk_bit;
      for (int i = 0; i < LVDS_LANES; i++) begin
        lane_sr_d[i][wr_pos] = lvds_data_bit[i];
      end
      bit_idx_d      = (bit_idx_q == LAST_IDX) ? 3'd0 : bit_idx_q + 3'd1;
      slip_pending_d = slip_req && (bit_idx_q == LAST_IDX);
    end
  end

  // The next-state view already contains the bit arriving this cycle.
  always_comb begin
    clk_word = clk_sr_d;
    for (int i = 0; i < LVDS_LANES; i++) begin
      data_word[i*LVDS_BITS_PER_FRAME +: LVDS_BITS_PER_FRAME] = lane_sr_d[i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      bit_idx_q      <= '0;
      slip_pending_q <= 1'b0;
      clk_sr_q       <= '0;
      lane_sr_q      <= '0;
    end else begin
      bit_idx_q      <= bit_idx_d;
      slip_pending_q <= slip_pending_d;
      clk_sr_q       <= clk_sr_d;
      lane_sr_q      <= lane_sr_d;
    end
  end

endmodule

// File: rtl/lvds_rx_align_ctrl.sv
// Frame alignment FSM (SEARCH/VERIFY/LOCKED); emits a 28-bit word 1 cycle after each locked frame end.
// No backpressure. Optional relock/frame-error counters under LVDS_ALIGN_STATS_EN.
module lvds_rx_align_ctrl
  import lvds_rx_pkg::*;
#(
  parameter frame_word_t CLK_PATTERN  = DEFAULT_CLK_PATTERN,
  parameter int unsigned LOCK_MATCHES = 4,
  parameter int unsigned UNLOCK_ERRS  = 2
) (
  input  logic                 clk_in,
  input  logic                 reset,
  lvds_rx_align_ctrl_if.slave  bus
);

  localparam logic [3:0] LOCK_MATCHES_C = 4'(LOCK_MATCHES);
  localparam logic [3:0] UNLOCK_ERRS_C  = 4'(UNLOCK_ERRS);
  localparam logic [2:0] SLIP_LAST      = 3'(LVDS_BITS_PER_FRAME - 1);

  align_state_e state_q, state_d;
  logic [3:0]   match_cnt_q, match_cnt_d;
  logic [3:0]   err_cnt_q, err_cnt_d;
  logic [2:0]   slip_cnt_q, slip_cnt_d;
  lvds_word_t   data_out_q, data_out_d;
  logic         data_valid_q, data_valid_d;
  logic         locked_q, locked_d;
  logic         align_err_q, align_err_d;
`ifdef LVDS_ALIGN_STATS_EN
  logic [7:0]   relock_cnt_q, relock_cnt_d;
  logic [15:0]  frame_err_cnt_q, frame_err_cnt_d;
`endif

  frame_word_t  clk_word;
  lvds_word_t   data_word;
  logic         frame_end, slip_req, slip_now, emit, clk_match;

  lvds_frame_shifter u_shifter (
    .clk_in        (clk_in),
    .reset         (reset),
    .run           (bus.enable),
    .slip_req      (slip_req),
    .lvds_clk_bit  (bus.lvds_clk_bit),
    .lvds_data_bit (bus.lvds_data_bit),
    .clk_word      (clk_word),
    .data_word     (data_word),
    .frame_end     (frame_end),
    .slip_pulse    (bus.slip_pulse)
  );

  assign clk_match = (clk_word == CLK_PATTERN);

  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    err_cnt_d    = err_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    align_err_d  = 1'b0;
    slip_now     = 1'b0;
    emit         = 1'b0;
`ifdef LVDS_ALIGN_STATS_EN
    relock_cnt_d    = relock_cnt_q;
    frame_err_cnt_d = frame_err_cnt_q;
`endif
    if (!bus.enable) begin
      state_d     = ST_IDLE;
      match_cnt_d = '0;
      err_cnt_d   = '0;
      slip_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEARCH;
        ST_SEARCH, ST_VERIFY: begin
          if (frame_end) begin
            if (clk_match) begin
              slip_cnt_d = '0;
              if (match_cnt_q + 4'd1 >= LOCK_MATCHES_C) begin
                state_d     = ST_LOCKED;
                match_cnt_d = '0;
                emit        = 1'b1;
              end else begin
                state_d     = ST_VERIFY;
                match_cnt_d = match_cnt_q + 4'd1;
              end
            end else begin
              state_d     = ST_SEARCH;
              match_cnt_d = '0;
              slip_now    = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (frame_end) begin
            emit = 1'b1;
            if (clk_match) begin
              err_cnt_d = '0;
            end else begin
              err_cnt_d = err_cnt_q + 4'd1;
`ifdef LVDS_ALIGN_STATS_EN
              if (frame_err_cnt_q != '1) frame_err_cnt_d = frame_err_cnt_q + 16'd1;
`endif
              // Unlock keeps current alignment: the next frame is retried unslipped.
              if (err_cnt_q + 4'd1 >= UNLOCK_ERRS_C) begin
                state_d   = ST_SEARCH;
                err_cnt_d = '0;
`ifdef LVDS_ALIGN_STATS_EN
                if (relock_cnt_q != '1) relock_cnt_d = relock_cnt_q + 8'd1;
`endif
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (slip_now) begin
      align_err_d = (slip_cnt_q == SLIP_LAST);
      slip_cnt_d  = (slip_cnt_q == SLIP_LAST) ? 3'd0 : slip_cnt_q + 3'd1;
    end
    if (emit) begin
      data_valid_d = 1'b1;
      data_out_d   = data_word;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  assign slip_req = slip_now;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      match_cnt_q  <= '0;
      err_cnt_q    <= '0;
      slip_cnt_q   <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      align_err_q  <= 1'b0;
`ifdef LVDS_ALIGN_STATS_EN
      relock_cnt_q    <= '0;
      frame_err_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      err_cnt_q    <= err_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      locked_q     <= locked_d;
      align_err_q  <= align_err_d;
`ifdef LVDS_ALIGN_STATS_EN
      relock_cnt_q    <= relock_cnt_d;
      frame_err_cnt_q <= frame_err_cnt_d;
`endif
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.locked     = locked_q;
  assign bus.align_err  = align_err_q;
`ifdef LVDS_ALIGN_STATS_EN
  assign bus.relock_cnt    = relock_cnt_q;
  assign bus.frame_err_cnt = frame_err_cnt_q;
`endif

endmodule
